// File: rtl/updi_prog_sequencer.sv
// UPDI programming-session sequencer: break, keys, status polls, signature read,
// block program/verify, with bounded retries, per-wait timeout and error codes.
module updi_prog_sequencer #(
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_BITS   = $clog2(TIMEOUT_CYCLES + 1),
    parameter int unsigned POLL_LIMIT     = 255,
    parameter int unsigned RETRY_BITS     = $clog2(MAX_RETRIES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            error_code,
    output logic [RETRY_BITS-1:0] retry_count,
    output logic                  break_start,
    input  logic                  break_done,
    output logic                  op_valid,
    output logic [2:0]            op_code,
    input  logic                  op_ready,
    input  logic                  op_done,
    input  logic                  op_ack_error,
    input  logic                  op_rx_valid,
    input  logic [7:0]            op_rx_data,
    output logic                  rom_rewind,
    output logic                  block_start,
    input  logic                  block_ready,
    input  logic                  block_last,
    output logic [23:0]           device_id,
    output logic                  device_id_valid
);

    typedef enum logic [3:0] {
        S_IDLE, S_BREAK_REQ, S_BREAK_WAIT, S_OP_REQ, S_OP_WAIT,
        S_BLK_REWIND, S_BLK_START, S_BLK_WAIT, S_FINISH
    } state_t;

    typedef enum logic [3:0] {
        PH_KEY_ERASE, PH_RST_A1, PH_RST_R1, PH_POLL_ERASE, PH_KEY_NVM,
        PH_RST_A2, PH_RST_R2, PH_POLL_NVM, PH_READ_ID, PH_PROGRAM, PH_VERIFY
    } phase_t;

    localparam int unsigned POLL_BITS = $clog2(POLL_LIMIT + 1);

    state_t                  state_q, state_d;
    phase_t                  phase_q, phase_d, nxt;
    logic [1:0]              mode_q, mode_d;
    logic [RETRY_BITS-1:0]   retry_q, retry_d;
    logic [2:0]              code_q, code_d, fin_code;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic [POLL_BITS-1:0]    poll_q, poll_d;
    logic [7:0]              status_q, status_d, status_now;
    logic                    mism_q, mism_d, mism_now;
    logic [23:0]             dev_id_q, dev_id_d;
    logic                    dev_valid_q, dev_valid_d;

    logic in_op, accept, rx_now, complete, fail_ack, tmo_hit;
    logic waiting, evt_now, issue, go_next, go_fin;

    // The op window opens on the accept cycle so ready+done together completes the op.
    assign in_op      = (state_q == S_OP_WAIT) || (state_q == S_OP_REQ && op_ready);
    assign accept     = (state_q == S_OP_REQ) && op_ready;
    assign rx_now     = in_op && op_rx_valid;
    assign status_now = rx_now ? op_rx_data : status_q;
    assign mism_now   = mism_q || (rx_now && op_rx_data != 8'h00);
    assign fail_ack   = in_op && op_ack_error;
    assign complete   = in_op && op_done && !op_ack_error;
    assign tmo_hit    = waiting && !evt_now && (tmo_q == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));

    always_comb begin
        waiting = 1'b1;
        evt_now = 1'b0;
        case (state_q)
            S_BREAK_WAIT: evt_now = break_done;
            S_OP_REQ:     evt_now = op_ready;
            S_OP_WAIT:    evt_now = op_done || op_ack_error;
            S_BLK_WAIT:   evt_now = block_ready || block_last;
            default:      waiting = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        mode_d      = mode_q;
        retry_d     = retry_q;
        code_d      = code_q;
        poll_d      = poll_q;
        status_d    = status_q;
        mism_d      = mism_q;
        dev_id_d    = dev_id_q;
        dev_valid_d = dev_valid_q;
        issue       = 1'b0;
        go_next     = 1'b0;
        nxt         = phase_q;
        go_fin      = 1'b0;
        fin_code    = 3'd0;

        if (in_op) begin
            status_d = status_now;
            mism_d   = mism_now;
            if (rx_now && phase_q == PH_READ_ID)
                dev_id_d = {dev_id_q[15:0], op_rx_data};
        end

        if (fail_ack || tmo_hit) begin
            if (retry_q < RETRY_BITS'(MAX_RETRIES)) begin
                retry_d     = retry_q + 1'b1;
                dev_valid_d = 1'b0;
                state_d     = S_BREAK_REQ;
            end else begin
                go_fin   = 1'b1;
                fin_code = fail_ack ? 3'd1 : 3'd2;
            end
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    mode_d      = (mode == 2'd3) ? 2'd0 : mode;
                    code_d      = 3'd0;
                    retry_d     = '0;
                    dev_valid_d = 1'b0;
                    state_d     = S_BREAK_REQ;
                end
                S_BREAK_REQ:  state_d = S_BREAK_WAIT;
                S_BREAK_WAIT: if (break_done) begin
                    go_next = 1'b1;
                    nxt     = PH_KEY_ERASE;
                end
                S_OP_REQ, S_OP_WAIT: begin
                    if (complete) begin
                        case (phase_q)
                            PH_KEY_ERASE: begin go_next = 1'b1; nxt = PH_RST_A1;     end
                            PH_RST_A1:    begin go_next = 1'b1; nxt = PH_RST_R1;     end
                            PH_RST_R1:    begin go_next = 1'b1; nxt = PH_POLL_ERASE; end
                            PH_KEY_NVM:   begin go_next = 1'b1; nxt = PH_RST_A2;     end
                            PH_RST_A2:    begin go_next = 1'b1; nxt = PH_RST_R2;     end
                            PH_RST_R2:    begin go_next = 1'b1; nxt = PH_POLL_NVM;   end
                            PH_POLL_ERASE, PH_POLL_NVM: begin
                                if (phase_q == PH_POLL_ERASE && !status_now[0]) begin
                                    if (mode_q == 2'd2) go_fin = 1'b1;
                                    else begin go_next = 1'b1; nxt = PH_KEY_NVM; end
                                end else if (phase_q == PH_POLL_NVM && status_now[3]) begin
                                    go_next = 1'b1;
                                    nxt     = PH_READ_ID;
                                end else if (poll_q == POLL_BITS'(POLL_LIMIT - 1)) begin
                                    go_fin   = 1'b1;
                                    fin_code = 3'd3;
                                end else begin
                                    poll_d  = poll_q + 1'b1;
                                    state_d = S_OP_REQ;
                                    issue   = 1'b1;
                                end
                            end
                            PH_READ_ID: begin
                                dev_valid_d = 1'b1;
                                phase_d     = PH_PROGRAM;
                                state_d     = S_BLK_REWIND;
                            end
                            PH_VERIFY: begin
                                if (mism_now) begin
                                    go_fin   = 1'b1;
                                    fin_code = 3'd4;
                                end else begin
                                    state_d = S_BLK_START;
                                end
                            end
                            default: state_d = S_BLK_START;
                        endcase
                    end else if (accept) begin
                        state_d = S_OP_WAIT;
                    end
                end
                S_BLK_REWIND: state_d = S_BLK_START;
                S_BLK_START:  state_d = S_BLK_WAIT;
                S_BLK_WAIT: begin
                    if (block_last) begin
                        if (phase_q == PH_PROGRAM && mode_q == 2'd0) begin
                            phase_d = PH_VERIFY;
                            state_d = S_BLK_REWIND;
                        end else begin
                            go_fin = 1'b1;
                        end
                    end else if (block_ready) begin
                        state_d = S_OP_REQ;
                        issue   = 1'b1;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end

        if (go_next) begin
            phase_d = nxt;
            poll_d  = '0;
            state_d = S_OP_REQ;
            issue   = 1'b1;
        end
        if (go_fin) begin
            state_d = S_FINISH;
            code_d  = fin_code;
        end
        // Status preloads as "erase busy, NVMPROG clear" so a poll with no byte never succeeds.
        if (issue) begin
            status_d = 8'h01;
            mism_d   = 1'b0;
        end
        tmo_d = (!waiting || state_d != state_q || issue || accept) ? '0 : tmo_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_KEY_ERASE;
            mode_q      <= 2'd0;
            retry_q     <= '0;
            code_q      <= 3'd0;
            tmo_q       <= '0;
            poll_q      <= '0;
            status_q    <= 8'h00;
            mism_q      <= 1'b0;
            dev_id_q    <= '0;
            dev_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            mode_q      <= mode_d;
            retry_q     <= retry_d;
            code_q      <= code_d;
            tmo_q       <= tmo_d;
            poll_q      <= poll_d;
            status_q    <= status_d;
            mism_q      <= mism_d;
            dev_id_q    <= dev_id_d;
            dev_valid_q <= dev_valid_d;
        end
    end

    always_comb begin
        op_code = 3'd0;
        if (state_q == S_OP_REQ) begin
            case (phase_q)
                PH_RST_A1, PH_RST_A2:     op_code = 3'd0;
                PH_RST_R1, PH_RST_R2:     op_code = 3'd1;
                PH_POLL_ERASE, PH_POLL_NVM: op_code = 3'd2;
                PH_KEY_ERASE:             op_code = 3'd3;
                PH_KEY_NVM:               op_code = 3'd4;
                PH_READ_ID:               op_code = 3'd5;
                PH_PROGRAM:               op_code = 3'd6;
                default:                  op_code = 3'd7;
            endcase
        end
    end

    assign busy            = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done            = (state_q == S_FINISH);
    assign error           = done && (code_q != 3'd0);
    assign error_code      = code_q;
    assign retry_count     = retry_q;
    assign break_start     = (state_q == S_BREAK_REQ);
    assign op_valid        = (state_q == S_OP_REQ);
    assign rom_rewind      = (state_q == S_BLK_REWIND);
    assign block_start     = (state_q == S_BLK_START);
    assign device_id       = dev_id_q;
    assign device_id_valid = dev_valid_q;

endmodule

// File: tb/tb_updi_prog_sequencer.sv
// Directed bench: a responder models PHY, instruction builder and ROM; expected
// op codes are queued per session and popped as the DUT issues operations.
module tb_updi_prog_sequencer;

    localparam int unsigned MAX_RETRIES    = 3;
    localparam int unsigned TIMEOUT_CYCLES = 100;
    localparam int unsigned POLL_LIMIT     = 4;
    localparam int unsigned RB             = $clog2(MAX_RETRIES + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          busy, done, error;
    logic [2:0]    error_code;
    logic [RB-1:0] retry_count;
    logic          break_start;
    logic          break_done = 1'b0;
    logic          op_valid;
    logic [2:0]    op_code;
    logic          op_ready = 1'b0, op_done = 1'b0, op_ack_error = 1'b0;
    logic          op_rx_valid = 1'b0;
    logic [7:0]    op_rx_data = 8'h00;
    logic          rom_rewind, block_start;
    logic          block_ready = 1'b0, block_last = 1'b0;
    logic [23:0]   device_id;
    logic          device_id_valid;

    updi_prog_sequencer #(
        .MAX_RETRIES   (MAX_RETRIES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .POLL_LIMIT    (POLL_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .error(error), .error_code(error_code),
        .retry_count(retry_count), .break_start(break_start), .break_done(break_done),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
        .op_ack_error(op_ack_error), .op_rx_valid(op_rx_valid), .op_rx_data(op_rx_data),
        .rom_rewind(rom_rewind), .block_start(block_start), .block_ready(block_ready),
        .block_last(block_last), .device_id(device_id), .device_id_valid(device_id_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] exp_ops[$];
    logic [7:0] stat_q[$];
    logic [7:0] ver_q[$];
    logic [7:0] rsp[$];
    int  nblocks = 2;
    bit  no_break = 1'b0;
    int  ack_left = 0;

    int  brk_cnt = 0, blk_cnt = 0, done_cnt = 0, stray_err = 0;
    logic       last_err = 1'b0, last_busy = 1'b0;
    logic [2:0] last_code = 3'd0;
    logic [RB-1:0] last_retry = '0;

    int  brk_wait = -1, blk_wait = -1, blk_idx = 0;
    bit  op_busy = 1'b0, pend_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Responder: samples DUT outputs 1 time unit after the falling edge and drives 1-cycle pulses.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            break_done = 1'b0; op_ready = 1'b0; op_done = 1'b0; op_ack_error = 1'b0;
            op_rx_valid = 1'b0; block_ready = 1'b0; block_last = 1'b0;
            if (rst) begin
                brk_wait = -1; blk_wait = -1; op_busy = 1'b0; rsp = {};
                continue;
            end
            if (done) begin
                done_cnt++;
                last_err = error; last_code = error_code;
                last_retry = retry_count; last_busy = busy;
            end
            if (error && !done) stray_err++;
            if (break_start) brk_cnt++;
            if (block_start) blk_cnt++;

            if (brk_wait > 0) begin
                brk_wait--;
                if (brk_wait == 0) begin break_done = 1'b1; brk_wait = -1; end
            end
            if (break_start && !no_break) brk_wait = 3;

            if (rom_rewind) blk_idx = 0;
            if (blk_wait > 0) begin
                blk_wait--;
                if (blk_wait == 0) begin
                    blk_wait = -1;
                    if (blk_idx < nblocks) begin block_ready = 1'b1; blk_idx++; end
                    else block_last = 1'b1;
                end
            end
            if (block_start) blk_wait = 2;

            if (op_busy) begin
                if (rsp.size() > 0) begin
                    op_rx_valid = 1'b1;
                    op_rx_data  = rsp.pop_front();
                end else begin
                    op_done      = 1'b1;
                    op_ack_error = pend_ack;
                    op_busy      = 1'b0;
                end
            end else if (op_valid) begin
                if (exp_ops.size() > 0) check("op_order", 32'(op_code), 32'(exp_ops.pop_front()));
                else check("op_extra", 32'(op_code), 32'hFF);
                op_ready = 1'b1;
                pend_ack = 1'b0;
                rsp = {};
                case (op_code)
                    3'd0, 3'd1: op_done = 1'b1;
                    3'd2: rsp.push_back(stat_q.size() > 0 ? stat_q.pop_front() : 8'h01);
                    3'd4: if (ack_left > 0) begin ack_left--; pend_ack = 1'b1; end
                    3'd5: rsp = '{8'h1E, 8'h93, 8'h23};
                    3'd7: rsp.push_back(ver_q.size() > 0 ? ver_q.pop_front() : 8'h00);
                    default: ;
                endcase
                if (!op_done) op_busy = 1'b1;
            end
        end
    end

    task automatic do_start(input logic [1:0] m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt != d0) break;
        end
        if (done_cnt == d0) begin
            n_cmp++;
            n_err++;
            $error("FAIL wait_done: observed no done after %0d cycles, expected done pulse", budget);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_done"},   32'(done), 32'd0);
        check({tag, "_error"},  32'(error), 32'd0);
        check({tag, "_code"},   32'(error_code), 32'd0);
        check({tag, "_retry"},  32'(retry_count), 32'd0);
        check({tag, "_opv"},    32'(op_valid), 32'd0);
        check({tag, "_opc"},    32'(op_code), 32'd0);
        check({tag, "_brk"},    32'(break_start), 32'd0);
        check({tag, "_blk"},    32'(block_start), 32'd0);
        check({tag, "_rew"},    32'(rom_rewind), 32'd0);
        check({tag, "_id"},     32'(device_id), 32'd0);
        check({tag, "_idv"},    32'(device_id_valid), 32'd0);
    endtask

    int d0, b0, k0;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // mode 0: full erase + program + verify
        stat_q = '{8'h00, 8'h08}; ver_q = '{8'h00, 8'h00}; nblocks = 2;
        exp_ops = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
        d0 = done_cnt; b0 = brk_cnt; k0 = blk_cnt;
        do_start(2'd0);
        check("m0_busy_after_start", 32'(busy), 32'd1);
        wait_done(d0, 2000);
        check("m0_error", 32'(last_err), 32'd0);
        check("m0_code", 32'(last_code), 32'd0);
        check("m0_busy_at_done", 32'(last_busy), 32'd0);
        check("m0_devid", 32'(device_id), 32'h1E9323);
        check("m0_devid_valid", 32'(device_id_valid), 32'd1);
        check("m0_ops_left", 32'(exp_ops.size()), 32'd0);
        check("m0_breaks", 32'(brk_cnt - b0), 32'd1);
        check("m0_block_starts", 32'(blk_cnt - k0), 32'd6);
        @(negedge clk);
        check("m0_idle_busy", 32'(busy), 32'd0);

        // mode 2: erase only, two busy polls
        stat_q = '{8'h01, 8'h01, 8'h00};
        exp_ops = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2};
        d0 = done_cnt;
        do_start(2'd2);
        wait_done(d0, 2000);
        check("m2_code", 32'(last_code), 32'd0);
        check("m2_error", 32'(last_err), 32'd0);
        check("m2_ops_left", 32'(exp_ops.size()), 32'd0);
        check("m2_devid_valid", 32'(device_id_valid), 32'd0);

        // ack error on first NVMPROG key, session recovers via one retry
        stat_q = '{8'h00, 8'h00, 8'h08}; nblocks = 2; ack_left = 1;
        exp_ops = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4,
                    3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd6};
        d0 = done_cnt; b0 = brk_cnt;
        do_start(2'd1);
        wait_done(d0, 3000);
        check("ack_breaks", 32'(brk_cnt - b0), 32'd2);
        check("ack_retry", 32'(last_retry), 32'd1);
        check("ack_error", 32'(last_err), 32'd0);
        check("ack_code", 32'(last_code), 32'd0);
        check("ack_ops_left", 32'(exp_ops.size()), 32'd0);
        check("ack_devid_valid", 32'(device_id_valid), 32'd1);

        // break_done never arrives: retries exhaust on timeout
        no_break = 1'b1; exp_ops = {};
        d0 = done_cnt; b0 = brk_cnt;
        do_start(2'd0);
        wait_done(d0, 2000);
        check("tmo_breaks", 32'(brk_cnt - b0), 32'd4);
        check("tmo_error", 32'(last_err), 32'd1);
        check("tmo_code", 32'(last_code), 32'd2);
        check("tmo_retry", 32'(last_retry), 32'd3);
        @(negedge clk);
        check("tmo_code_held", 32'(error_code), 32'd2);
        no_break = 1'b0;

        // verify mismatch on the second block
        stat_q = '{8'h00, 8'h08}; ver_q = '{8'h00, 8'h5A}; nblocks = 2;
        exp_ops = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
        d0 = done_cnt; k0 = blk_cnt;
        do_start(2'd3);
        wait_done(d0, 2000);
        check("vfy_error", 32'(last_err), 32'd1);
        check("vfy_code", 32'(last_code), 32'd4);
        check("vfy_retry", 32'(last_retry), 32'd0);
        check("vfy_block_starts", 32'(blk_cnt - k0), 32'd5);
        check("vfy_ops_left", 32'(exp_ops.size()), 32'd0);

        // poll limit: every status read reports erase still locked
        stat_q = '{8'h01, 8'h01, 8'h01, 8'h01};
        exp_ops = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
        d0 = done_cnt;
        do_start(2'd2);
        wait_done(d0, 2000);
        check("poll_error", 32'(last_err), 32'd1);
        check("poll_code", 32'(last_code), 32'd3);
        check("poll_ops_left", 32'(exp_ops.size()), 32'd0);
        check("stray_error", 32'(stray_err), 32'd0);

        // reset in the middle of PROGRAM, then a clean session
        stat_q = '{8'h00, 8'h08}; nblocks = 2;
        exp_ops = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd5, 3'd6};
        d0 = done_cnt;
        do_start(2'd0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #2;
            if (exp_ops.size() == 0) break;
        end
        check("rst_reached_program", 32'(exp_ops.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt), 32'(d0));
        check("midrst_idle", 32'(busy), 32'd0);
        stat_q = '{8'h00};
        exp_ops = '{3'd3, 3'd0, 3'd1, 3'd2};
        d0 = done_cnt; b0 = brk_cnt;
        do_start(2'd2);
        check("post_rst_break", 32'(break_start), 32'd1);
        wait_done(d0, 2000);
        check("post_rst_breaks", 32'(brk_cnt - b0), 32'd1);
        check("post_rst_code", 32'(last_code), 32'd0);
        check("post_rst_ops_left", 32'(exp_ops.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/updi_prog_sequencer.md
Name: updi_prog_sequencer

Overview:
Parametrised programming-sequence controller, the successor to the programmer top-level FSM. Drives the complete UPDI session: double-break, chip-erase key, NVMPROG key, status polling, device-ID read, block program and optional verify. Adds selectable modes, bounded retries, per-wait timeout and error reporting. Issues abstract operations to the instruction builder, which sits above updi_interface, and block requests to program_rom.

Parameters:
MAX_RETRIES, 3, session restarts allowed after a retryable failure
TIMEOUT_CYCLES, 1000000, max clk cycles waiting on any op_done, break_done or block response
TIMEOUT_BITS, $clog2(TIMEOUT_CYCLES+1), timeout counter width
POLL_LIMIT, 255, max READ_STATUS ops per poll phase
RETRY_BITS, $clog2(MAX_RETRIES+1), retry counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin session; sampled only in IDLE
mode  in  2  0=erase+program+verify, 1=erase+program, 2=erase only, 3=reserved (treated as 0); latched on start
busy  out  1  high from the cycle after start until done
done  out  1  1-cycle completion pulse
error  out  1  1-cycle pulse coincident with done on failure
error_code  out  3  0 ok, 1 ack error / retries exhausted, 2 timeout, 3 poll limit, 4 verify mismatch; held until next start
retry_count  out  RETRY_BITS  restarts used in this session
break_start  out  1  1-cycle pulse to PHY double-break
break_done  in  1  double-break complete pulse
op_valid  out  1  operation request
op_code  out  3  0 RST_ASSERT, 1 RST_RELEASE, 2 READ_STATUS, 3 KEY_ERASE, 4 KEY_NVMPROG, 5 READ_SIGROW, 6 WRITE_BLOCK, 7 VERIFY_BLOCK
op_ready  in  1  operation accepted
op_done  in  1  operation complete pulse
op_ack_error  in  1  ACK failure pulse
op_rx_valid  in  1  response byte strobe
op_rx_data  in  8  response byte
rom_rewind  out  1  1-cycle pulse: restart ROM at first block
block_start  out  1  1-cycle pulse: fetch next block
block_ready  in  1  block loaded
block_last  in  1  no more blocks (ROM done)
device_id  out  24  signature bytes, first received in [23:16]
device_id_valid  out  1  set after READ_SIGROW op_done; cleared on start

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. A reset mid-session aborts immediately with no done pulse. The next start runs a clean session.
- Handshake: op_valid and op_code stay stable until the cycle op_ready=1. op_valid drops the next cycle. The block then waits for op_done. op_rx_valid bytes are captured between acceptance and op_done.
- Simultaneous events: op_ack_error together with op_done means failure. op_ready and op_done in the same cycle counts as accept plus complete.
- Sequence: IDLE -start-> BREAK -> KEY_ERASE -> RST_ASSERT -> RST_RELEASE -> POLL_ERASE.
  - POLL_ERASE repeats READ_STATUS until byte bit0 (LOCKSTATUS)=0.
  - mode 2 -> FINISH.
  - Otherwise: KEY_NVM -> RST_ASSERT -> RST_RELEASE -> POLL_NVM, which repeats until bit3 (NVMPROG)=1.
  - Then READ_ID (op 5, 3 bytes) -> PROGRAM -> VERIFY (mode 0 only) -> FINISH.
- PROGRAM / VERIFY loop:
  - Pulse rom_rewind on phase entry, then block_start, then wait for block_ready or block_last.
  - On block_ready: issue op 6 or op 7, then the next block_start after op_done.
  - On block_last: advance to the next phase.
  - VERIFY response byte: 0x00 = match; any nonzero byte means a mismatch.
- Timeout: counter clears on every state entry and op acceptance. It counts while waiting for any input pulse. Reaching TIMEOUT_CYCLES-1 raises a timeout event.
- Retryable events (ack error, timeout):
  - If retry_count < MAX_RETRIES: increment retry_count, go to BREAK, clear device_id_valid.
  - Otherwise: FINISH with code 1 (ack error) or 2 (timeout), whichever was the last event.
- Non-retryable events:
  - A poll phase issuing POLL_LIMIT READ_STATUS ops without success gives code 3.
  - A verify mismatch gives code 4.
- FINISH: 1-cycle done, and error if the code is nonzero; busy drops in the same cycle; then IDLE.
- start while busy is ignored. start in the FINISH cycle is ignored.

Test Plan:
- mode 0, model answers status 0x00 then 0x08, SIGROW 1E 93 23, 2 blocks, verify 0x00 -> device_id=0x1E9323, valid=1; op order 3,0,1,2,4,0,1,2,5,6,6,7,7; done with error=0.
- mode 2, status 0x01 twice then 0x00 -> three READ_STATUS ops, no op 4; done, error_code=0.
- op_ack_error on the first KEY_NVMPROG, MAX_RETRIES=3 -> second break_start pulse, retry_count=1, session completes with error=0.
- break_done never arrives, TIMEOUT_CYCLES=100 -> 4 break_start pulses; done+error, error_code=2, retry_count=3.
- verify returns 0x5A on the second block -> immediate done+error, error_code=4, retry_count unchanged.
- rst asserted mid-PROGRAM, then start again -> all outputs 0 after rst with no done pulse; new session begins with break_start.
